// File: rtl/spi_master_ctrl_if.sv
// Command/response bundle between the sequencer and the SPI master controller.
interface spi_master_ctrl_if #(parameter int ADDR_SIZE = 8);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [ADDR_SIZE-1:0] req_data;
  logic                 rsp_valid;
  logic [ADDR_SIZE-1:0] rsp_data;
  logic                 busy;
  logic                 err;

  modport master (output req_valid, req_op, req_data,
                  input  req_ready, rsp_valid, rsp_data, busy, err);
  modport slave  (input  req_valid, req_op, req_data,
                  output req_ready, rsp_valid, rsp_data, busy, err);
endinterface

// File: rtl/spi_master_ctrl.sv
// Command-level SPI master: frames {op,data} onto SS_n/MOSI, collects read-data replies from MISO.
// Optional op-sequence checking is enabled with `define SPI_MASTER_SEQ_CHECK_EN.
module spi_master_ctrl #(
  parameter int RD_LAT    = 2,
  parameter int GAP       = 1,
  parameter int ADDR_SIZE = 8
)(
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.slave  bus,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = 8;

  typedef enum logic [2:0] {IDLE, CMD, SHIFT, WAIT_RD, RX, GAP_ST} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [FW-1:0]        din;
  logic                 rd_frame;
  logic [ADDR_SIZE-2:0] rx_sh;
  logic                 req_ready, rsp_valid, busy;
  logic [ADDR_SIZE-1:0] rsp_data;
  logic                 accept, reject, start;

  assign accept = bus.req_valid && req_ready;
  assign start  = accept && !reject;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.busy      = busy;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic wa_seen, last_ra, err;

  // Rejected commands do not update history; only framed ops count.
  assign reject = (bus.req_op == 2'b01 && !wa_seen) ||
                  (bus.req_op == 2'b11 && !last_ra);
  assign bus.err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      wa_seen <= 1'b0;
      last_ra <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= accept && reject;
      if (start) begin
        if (bus.req_op == 2'b00) wa_seen <= 1'b1;
        last_ra <= (bus.req_op == 2'b10);
      end
    end
  end
`else
  assign reject  = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      din       <= '0;
      rd_frame  <= 1'b0;
      rx_sh     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (start) begin
            din       <= {bus.req_op, bus.req_data};
            rd_frame  <= (bus.req_op == 2'b11);
            state     <= CMD;
            SS_n      <= 1'b0;
            MOSI      <= bus.req_op[1];
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CMD: begin
          state <= SHIFT;
          MOSI  <= din[FW-1];
          din   <= {din[FW-2:0], 1'b0};
          cnt   <= '0;
        end
        SHIFT: begin
          if (cnt == CW'(FW-1)) begin
            cnt  <= '0;
            MOSI <= 1'b0;
            if (rd_frame) begin
              state <= (RD_LAT == 0) ? RX : WAIT_RD;
            end else begin
              state <= GAP_ST;
              SS_n  <= 1'b1;
            end
          end else begin
            cnt  <= cnt + 1'b1;
            MOSI <= din[FW-1];
            din  <= {din[FW-2:0], 1'b0};
          end
        end
        WAIT_RD: begin
          if (cnt == CW'(RD_LAT-1)) begin
            cnt   <= '0;
            state <= RX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX: begin
          rx_sh <= {rx_sh[ADDR_SIZE-3:0], MISO};
          if (cnt == CW'(ADDR_SIZE-1)) begin
            rsp_data  <= {rx_sh, MISO};
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            state     <= GAP_ST;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP_ST: begin
          if (cnt == CW'(GAP-1)) begin
            cnt       <= '0;
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl; "phase k" = outputs seen at the k-th posedge after the accept edge.
module tb_spi_master_ctrl;
  localparam int RD_LAT = 2;
  localparam int GAP    = 1;
  localparam int RV_PH  = 12 + RD_LAT + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic MISO = 1'b0;
  logic SS_n, MOSI;
  int   total = 0;
  int   bad   = 0;

  spi_master_ctrl_if #(.ADDR_SIZE(8)) bus();

  spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a command, wait for ready, return at phase 1 with req_valid dropped.
  task automatic send(input logic [1:0] op, input logic [7:0] data);
    int n = 0;
    bus.req_op = op; bus.req_data = data; bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 60) begin tick(); n++; end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL send_timeout: req_ready got %b want 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req_valid = 1'b0; MISO = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 8'h00;
    tick(); tick();
    total++; if (SS_n !== 1'b1) begin bad++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
    total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin bad++;
      $display("FAIL rst_rsp: got %b/%h want 0/00", bus.rsp_valid, bus.rsp_data); end
    total++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin bad++;
      $display("FAIL rst_busy_err: got %b/%b want 0/0", bus.busy, bus.err); end
    rst = 1'b0;
    tick();
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write_add();
    logic [10:0] exp_mosi = 11'b00000111100;  // WRITE_ADD 0x3C
    send(2'b00, 8'h3C);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL wa_busy: got %b want 1", bus.busy); end
    for (int k = 1; k <= 11; k++) begin
      total++; if (SS_n !== 1'b0 || MOSI !== exp_mosi[11-k]) begin bad++;
        $display("FAIL wa_bit%0d: ss_n/mosi got %b/%b want 0/%b", k, SS_n, MOSI, exp_mosi[11-k]); end
      tick();
    end
    total++; if (SS_n !== 1'b1 || MOSI !== 1'b0 || bus.req_ready !== 1'b0) begin bad++;
      $display("FAIL wa_ph12: ss_n/mosi/ready got %b/%b/%b want 1/0/0", SS_n, MOSI, bus.req_ready); end
    tick();
    total++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL wa_ph13: ready/busy got %b/%b want 1/0", bus.req_ready, bus.busy); end
  endtask

  task automatic test_write_data();
    logic [10:0] exp_mosi = 11'b00110100101;  // WRITE_DATA 0xA5
    int rv = 0;
    send(2'b00, 8'h10);
    send(2'b01, 8'hA5);
    for (int k = 1; k <= 11; k++) begin
      if (bus.rsp_valid === 1'b1) rv++;
      total++; if (SS_n !== 1'b0 || MOSI !== exp_mosi[11-k]) begin bad++;
        $display("FAIL wd_bit%0d: ss_n/mosi got %b/%b want 0/%b", k, SS_n, MOSI, exp_mosi[11-k]); end
      tick();
    end
    for (int k = 12; k <= 14; k++) begin if (bus.rsp_valid === 1'b1) rv++; tick(); end
    total++; if (rv != 0) begin bad++; $display("FAIL wd_no_rsp: rsp_valid pulses got %0d want 0", rv); end
  endtask

  // Read-data frame from phase 1: slave drives the byte during RX, 1s elsewhere.
  task automatic check_read_frame(input logic [7:0] byte_v, input string nm);
    for (int k = 1; k <= RV_PH + 1; k++) begin
      MISO = (k >= 14 && k <= 21) ? byte_v[21-k] : 1'b1;
      if (k <= RV_PH - 1) begin
        total++; if (SS_n !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++;
          $display("FAIL %s_ph%0d: ss_n/rsp_valid got %b/%b want 0/0", nm, k, SS_n, bus.rsp_valid); end
      end else if (k == RV_PH) begin
        total++; if (SS_n !== 1'b1 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== byte_v) begin bad++;
          $display("FAIL %s_rsp: ss_n/valid/data got %b/%b/%h want 1/1/%h", nm, SS_n, bus.rsp_valid, bus.rsp_data, byte_v); end
      end else begin
        total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_data !== byte_v) begin bad++;
          $display("FAIL %s_after: valid/ready/data got %b/%b/%h want 0/1/%h", nm, bus.rsp_valid, bus.req_ready, bus.rsp_data, byte_v); end
      end
      tick();
    end
    MISO = 1'b0;
  endtask

  task automatic test_read();
    send(2'b10, 8'h10);
    MISO = 1'b1;
    send(2'b11, 8'h00);
    check_read_frame(8'hA5, "rd");
  endtask

  task automatic test_reset_mid();
    int rv = 0;
    logic [10:0] exp_mosi = 11'b00000111100;
    send(2'b10, 8'h20);
    send(2'b11, 8'h00);
    for (int k = 1; k < 7; k++) tick();
    rst = 1'b1;  // phase 7 = SHIFT bit 5
    tick();
    total++; if (SS_n !== 1'b1 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL mid_rst: ss_n/busy got %b/%b want 1/0", SS_n, bus.busy); end
    rst = 1'b0;
    MISO = 1'b1;
    for (int k = 0; k < 30; k++) begin if (bus.rsp_valid === 1'b1 || SS_n !== 1'b1) rv++; tick(); end
    MISO = 1'b0;
    total++; if (rv != 0) begin bad++; $display("FAIL mid_quiet: rsp/ss_n events got %0d want 0", rv); end
    send(2'b00, 8'h3C);
    for (int k = 1; k <= 11; k++) begin
      total++; if (SS_n !== 1'b0 || MOSI !== exp_mosi[11-k]) begin bad++;
        $display("FAIL mid_wa_bit%0d: ss_n/mosi got %b/%b want 0/%b", k, SS_n, MOSI, exp_mosi[11-k]); end
      tick();
    end
    for (int k = 12; k <= 13; k++) tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [9:0] got;
    int n, h;
    bus.req_op = ops[0]; bus.req_data = dat[0]; bus.req_valid = 1'b1;
    n = 0;
    while (SS_n !== 1'b0 && n < 40) begin tick(); n++; end
    total++; if (n >= 40) begin bad++; $display("FAIL b2b_start: ss_n got %b want 0", SS_n); end
    for (int f = 0; f < 4; f++) begin
      // at phase 1 of frame f: queue the next command or stop requesting
      if (f < 3) begin bus.req_op = ops[f+1]; bus.req_data = dat[f+1]; end
      else bus.req_valid = 1'b0;
      tick();
      for (int b = 0; b < 10; b++) begin got[9-b] = MOSI; tick(); end
      total++; if (got !== {ops[f], dat[f]}) begin bad++;
        $display("FAIL b2b_frame%0d: payload got %h want %h", f, got, {ops[f], dat[f]}); end
      h = 0;
      while (SS_n === 1'b1 && h < 20) begin tick(); h++; end
      // idle stretch = GAP cycles plus the IDLE cycle that accepts the next command
      if (f < 3) begin
        total++; if (h != GAP + 1) begin bad++; $display("FAIL b2b_gap%0d: high cycles got %0d want %0d", f, h, GAP + 1); end
      end else begin
        total++; if (h != 20) begin bad++; $display("FAIL b2b_extra: high cycles got %0d want 20", h); end
      end
    end
  endtask

  task automatic test_seq_check();
    do_reset();
`ifdef SPI_MASTER_SEQ_CHECK_EN
    send(2'b11, 8'h00);
    total++; if (bus.err !== 1'b1 || SS_n !== 1'b1 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL seq_rd: err/ss_n/ready/busy got %b/%b/%b/%b want 1/1/1/0", bus.err, SS_n, bus.req_ready, bus.busy); end
    tick();
    total++; if (bus.err !== 1'b0 || SS_n !== 1'b1) begin bad++;
      $display("FAIL seq_rd_next: err/ss_n got %b/%b want 0/1", bus.err, SS_n); end
    send(2'b01, 8'h55);
    total++; if (bus.err !== 1'b1 || SS_n !== 1'b1) begin bad++;
      $display("FAIL seq_wd: err/ss_n got %b/%b want 1/1", bus.err, SS_n); end
    tick();
`else
    MISO = 1'b1;
    send(2'b11, 8'h00);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL noseq_err: got %b want 0", bus.err); end
    check_read_frame(8'h3C, "noseq");
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 8'h00;
    test_reset();
    test_write_add();
    test_write_data();
    test_read();
    test_reset_mid();
    test_back_to_back();
    test_seq_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end
endmodule
